mem_bist: RTL and testbench

Built-in self-test initiator for the `mem_mod` single-port-pair memory. Drives the write and read ports of `mem_mod` through a write-pattern / read-compare march over every address, then reports pass/fail, first failing address and error count. Sits beside the memory. Owns the memory ports while `busy` is high, so no other master may drive them during a run.

---
 rtl/mem_bist.sv | 162 ++++++++++++++++
 tb/tb_mem_bist.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mem_bist.sv
// mem_bist: write-pattern / read-compare march BIST initiator for mem_mod.
// Define MEM_BIST_INV_PASS_EN to add the inverted-pattern WR1/RD1 pass.
module mem_bist #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    MAX_ADDR   = 16,
    parameter int                    ADDRSIZE   = $clog2(MAX_ADDR),
    parameter logic [DATA_WIDTH-1:0] SEED       = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDRSIZE-1:0]   fail_addr,
    output logic [ADDRSIZE+1:0]   err_count,
    output logic                  wr_en,
    output logic [ADDRSIZE-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_en,
    output logic [ADDRSIZE-1:0]   rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data
);

    typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, DONE} state_t;

    localparam logic [ADDRSIZE-1:0] LAST = ADDRSIZE'(MAX_ADDR - 1);

    state_t                  state;
    logic [ADDRSIZE-1:0]     cnt;
    logic                    first_seen;
    logic [DATA_WIDTH-1:0]   pat;
    logic [DATA_WIDTH-1:0]   expected;
    logic                    mismatch;
    logic                    last;

    // Address zero-extended or truncated to the word width, then XORed with SEED.
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDRSIZE-1:0] a);
        logic [DATA_WIDTH+ADDRSIZE-1:0] ext;
        ext = {{DATA_WIDTH{1'b0}}, a};
        return ext[DATA_WIDTH-1:0] ^ SEED;
    endfunction

    always_comb begin
        pat  = pattern(cnt);
        last = (cnt == LAST);
`ifdef MEM_BIST_INV_PASS_EN
        expected = (state == RD1) ? ~pat : pat;
`else
        expected = pat;
`endif
        mismatch = (rd_data != expected);
    end

    // Memory port and status outputs decode from state/counter flops only.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        case (state)
            WR0: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = cnt;
                wr_data = pat;
            end
            RD0: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                rd_addr = cnt;
            end
`ifdef MEM_BIST_INV_PASS_EN
            WR1: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = cnt;
                wr_data = ~pat;
            end
            RD1: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                rd_addr = cnt;
            end
`endif
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            first_seen <= 1'b0;
            pass       <= 1'b0;
            fail_addr  <= '0;
            err_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= WR0;
                        cnt        <= '0;
                        first_seen <= 1'b0;
                        fail_addr  <= '0;
                        err_count  <= '0;
                    end
                end
                WR0: begin
                    if (last) begin
                        state <= RD0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RD0, RD1: begin
                    if (mismatch) begin
                        err_count <= err_count + 1'b1;
                        if (!first_seen) begin
                            first_seen <= 1'b1;
                            fail_addr  <= cnt;
                        end
                    end
                    if (last) begin
                        cnt <= '0;
`ifdef MEM_BIST_INV_PASS_EN
                        if (state == RD0) begin
                            state <= WR1;
                        end else begin
                            state <= DONE;
                            pass  <= (err_count == '0) && !mismatch;
                        end
`else
                        state <= DONE;
                        pass  <= (err_count == '0) && !mismatch;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef MEM_BIST_INV_PASS_EN
                WR1: begin
                    if (last) begin
                        state <= RD1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bist.sv
// Self-checking bench for mem_bist: behavioural memory with injectable faults,
// expected write/read transactions queued at start and popped as the DUT issues them.
module tb_mem_bist;

`ifdef MEM_BIST_INV_PASS_EN
    localparam int PHASES = 4;
`else
    localparam int PHASES = 2;
`endif
    localparam int NW = 16;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, pass;
    logic [3:0] fail_addr;
    logic [5:0] err_count;
    logic       wr_en, rd_en;
    logic [3:0] wr_addr, rd_addr;
    logic [7:0] wr_data, rd_data;

    logic [7:0] mem [NW];
    int         fault = 0;
    int         checks = 0;
    int         errors = 0;
    wr_t        wq[$];
    logic [3:0] rq[$];

    always #5 clk = ~clk;

    mem_bist #(.DATA_WIDTH(8), .MAX_ADDR(16), .SEED(8'hA5)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .pass(pass), .fail_addr(fail_addr), .err_count(err_count),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always @(posedge clk) if (wr_en) mem[wr_addr] <= wr_data;

    // fault 1: bit 0 of address 5 stuck at 0; fault 2: read data stuck at 0
    always_comb begin
        rd_data = mem[rd_addr];
        if (fault == 1 && rd_addr == 4'd5) rd_data[0] = 1'b0;
        if (fault == 2) rd_data = 8'h00;
    end

    function automatic logic [7:0] pat(input int a);
        return 8'(a) ^ 8'hA5;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_test(input int fsel, input bit hold, input bit exp_pass,
                            input int exp_fa, input int exp_err);
        wr_t e;
        logic [3:0] ra;
        int n;
        @(negedge clk);
        check_eq("idle_busy", 32'(busy), 0);
        check_eq("idle_done", 32'(done), 0);
        fault = fsel;
        start = 1'b1;
        for (int ph = 0; ph < PHASES; ph++) begin
            for (int a = 0; a < NW; a++) begin
                if (ph % 2 == 0) begin
                    e.addr = 4'(a);
                    e.data = (ph == 0) ? pat(a) : ~pat(a);
                    wq.push_back(e);
                end else begin
                    rq.push_back(4'(a));
                end
            end
        end
        @(negedge clk);
        if (!hold) start = 1'b0;
        n = 1;
        check_eq("busy_t1", 32'(busy), 1);
        check_eq("err_clear_t1", 32'(err_count), 0);
        while (!done && n < 300) begin
            if (wr_en) begin
                check_eq("wr_unexpected", 32'(wq.size() > 0), 1);
                if (wq.size() > 0) begin
                    e = wq.pop_front();
                    check_eq("wr_addr", 32'(wr_addr), 32'(e.addr));
                    check_eq("wr_data", 32'(wr_data), 32'(e.data));
                end
            end else begin
                check_eq("wr_idle_zero", 32'({wr_addr, wr_data}), 0);
            end
            if (rd_en) begin
                check_eq("rd_unexpected", 32'(rq.size() > 0), 1);
                if (rq.size() > 0) begin
                    ra = rq.pop_front();
                    check_eq("rd_addr", 32'(rd_addr), 32'(ra));
                end
            end
            @(negedge clk);
            n++;
        end
        check_eq("done_seen", 32'(done), 1);
        check_eq("done_cycle", 32'(n), 32'(1 + PHASES * NW));
        check_eq("done_busy", 32'(busy), 0);
        check_eq("wq_left", 32'(wq.size()), 0);
        check_eq("rq_left", 32'(rq.size()), 0);
        check_eq("pass", 32'(pass), 32'(exp_pass));
        check_eq("fail_addr", 32'(fail_addr), 32'(exp_fa));
        check_eq("err_count", 32'(err_count), 32'(exp_err));
        wq.delete();
        rq.delete();
    endtask

    initial begin
        int target;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_pass", 32'(pass), 0);
        check_eq("rst_fail_addr", 32'(fail_addr), 0);
        check_eq("rst_err", 32'(err_count), 0);
        check_eq("rst_ports", 32'({wr_en, rd_en, wr_addr, wr_data, rd_addr}), 0);
        rst = 1'b0;

        run_test(0, 1'b0, 1'b1, 0, 0);
`ifdef MEM_BIST_INV_PASS_EN
        run_test(1, 1'b0, 1'b0, 5, 1);
`else
        run_test(1, 1'b0, 1'b1, 0, 0);
`endif
        run_test(2, 1'b0, 1'b0, 0, PHASES / 2 * NW);

        // start held high across two back-to-back runs
        run_test(2, 1'b1, 1'b0, 0, PHASES / 2 * NW);
        run_test(0, 1'b1, 1'b1, 0, 0);
        start = 1'b0;

        // asynchronous reset mid-run with a non-zero error count
        @(negedge clk);
        fault = 2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        target = (PHASES == 4) ? 1 + 2 * NW + 7 : 1 + 7;
        for (int i = 1; i < target; i++) @(negedge clk);
        check_eq("mid_wr_en", 32'(wr_en), 1);
        check_eq("mid_wr_addr", 32'(wr_addr), 7);
        #1 rst = 1'b1;
        #1;
        check_eq("arst_wr_en", 32'(wr_en), 0);
        check_eq("arst_busy", 32'(busy), 0);
        check_eq("arst_err", 32'(err_count), 0);
        check_eq("arst_pass", 32'(pass), 0);
        @(negedge clk);
        rst = 1'b0;
        fault = 0;
        run_test(0, 1'b0, 1'b1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
